// File: rtl/ai_pkg.sv
// ai_pkg: shared state encoding, default sizes and width helper for the match selector
package ai_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;
  localparam int CHUNKS_D = 64;
  localparam int TEMPLATES_D = 8;
  localparam int DIST_W_D = 10;
  function automatic int acc_w(input int dist_w, input int chunks);
    return dist_w + $clog2(chunks);
  endfunction
endpackage

// File: rtl/ai_min_tracker.sv
// ai_min_tracker: keeps the lowest template total seen so far and its index
module ai_min_tracker
  import ai_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [ACC_W-1:0] total,
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] best_dist,
  output logic [IDX_W-1:0] best_idx
);
  logic [ACC_W-1:0] r_dist;
  logic [IDX_W-1:0] r_idx;
  // strict-less update so an equal later total never displaces an earlier index
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dist <= '0;
      r_idx  <= '0;
    end else if (clr) begin
      r_dist <= '1;
      r_idx  <= '0;
    end else if (upd && total < r_dist) begin
      r_dist <= total;
      r_idx  <= idx;
    end
  end
  assign best_dist = r_dist;
  assign best_idx  = r_idx;
endmodule

// File: rtl/ai_match_selector.sv
// ai_match_selector: sums chunk distances per template and reports the closest template
module ai_match_selector
  import ai_pkg::*;
#(
  parameter int CHUNKS = CHUNKS_D,
  parameter int TEMPLATES = TEMPLATES_D,
  parameter int DIST_W = DIST_W_D,
  parameter int ACC_W = acc_w(DIST_W, CHUNKS),
  parameter int IDX_W = $clog2(TEMPLATES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [DIST_W-1:0] data_in,
  input  logic              rdy_in,
  output logic [IDX_W-1:0]  class_out,
  output logic [ACC_W-1:0]  dist_out,
  output logic              rdy_out,
  output logic              busy
);
  localparam int CW = $clog2(CHUNKS);
  state_t           r_state, w_next;
  logic [ACC_W-1:0] r_acc, w_acc, w_total, w_best_dist;
  logic [CW-1:0]    r_chunk, w_chunk;
  logic [IDX_W-1:0] r_tmpl, w_tmpl, w_best_idx, r_class;
  logic [ACC_W-1:0] r_dist;
  logic             r_rdy, w_rdy, w_clr, w_upd;
  ai_min_tracker #(.ACC_W(ACC_W), .IDX_W(IDX_W)) u_min (
    .clk(clk), .rst(rst), .clr(w_clr), .upd(w_upd), .total(w_total), .idx(r_tmpl),
    .best_dist(w_best_dist), .best_idx(w_best_idx)
  );
  // next-state and datapath updates; init wins over a same-cycle rdy_in
  always_comb begin
    w_total = r_acc + ACC_W'(data_in);
    w_next  = r_state;
    w_acc   = r_acc;
    w_chunk = r_chunk;
    w_tmpl  = r_tmpl;
    w_clr   = 1'b0;
    w_upd   = 1'b0;
    w_rdy   = 1'b0;
    if (init) begin
      w_next  = ACCUM;
      w_acc   = '0;
      w_chunk = '0;
      w_tmpl  = '0;
      w_clr   = 1'b1;
    end else if (r_state == ACCUM && rdy_in) begin
      if (r_chunk == CW'(CHUNKS - 1)) begin
        w_upd   = 1'b1;
        w_acc   = '0;
        w_chunk = '0;
        w_tmpl  = r_tmpl + IDX_W'(1);
        w_next  = r_tmpl == IDX_W'(TEMPLATES - 1) ? RESULT : ACCUM;
      end else begin
        w_acc   = w_total;
        w_chunk = r_chunk + CW'(1);
      end
    end else if (r_state == RESULT) begin
      w_next = IDLE;
      w_rdy  = 1'b1;
    end
  end
  // state, accumulator and held result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_chunk <= '0;
      r_tmpl  <= '0;
      r_class <= '0;
      r_dist  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_acc   <= w_acc;
      r_chunk <= w_chunk;
      r_tmpl  <= w_tmpl;
      r_rdy   <= w_rdy;
      if (w_rdy) begin
        r_class <= w_best_idx;
        r_dist  <= w_best_dist;
      end
    end
  end
  assign class_out = r_class;
  assign dist_out  = r_dist;
  assign rdy_out   = r_rdy;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_ai_match_selector.sv
// tb_ai_match_selector: randomized scoreboard bench for two sizes of the match selector
module tb_ai_match_selector;
  typedef struct {int c; int d;} res_t;
  logic clk = 1'b0, rst = 1'b0;
  logic init_v [2];
  logic rdy_v [2];
  logic [9:0] data_v [2];
  logic [1:0] cls_a;
  logic [11:0] dist_a;
  logic cls_b;
  logic [15:0] dist_b;
  logic rdy_a, rdy_b, busy_a, busy_b;
  int checks = 0, failures = 0;
  res_t sb [2][$];
  int stream [$];

  always #5 clk = ~clk;

  ai_match_selector #(.CHUNKS(4), .TEMPLATES(3), .DIST_W(10)) dut_a (
    .clk(clk), .rst(rst), .init(init_v[0]), .data_in(data_v[0]), .rdy_in(rdy_v[0]),
    .class_out(cls_a), .dist_out(dist_a), .rdy_out(rdy_a), .busy(busy_a)
  );
  ai_match_selector #(.CHUNKS(64), .TEMPLATES(2), .DIST_W(10)) dut_b (
    .clk(clk), .rst(rst), .init(init_v[1]), .data_in(data_v[1]), .rdy_in(rdy_v[1]),
    .class_out(cls_b), .dist_out(dist_b), .rdy_out(rdy_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdy_of(input int s);
    return s ? 32'(rdy_b) : 32'(rdy_a);
  endfunction

  function automatic logic [31:0] busy_of(input int s);
    return s ? 32'(busy_b) : 32'(busy_a);
  endfunction

  // scoreboard monitor: every result strobe must match the oldest expected result
  always @(negedge clk) begin
    res_t r;
    if (rdy_a) begin
      if (sb[0].size() == 0) chk("unexpected_rdy_a", 1, 0);
      else begin
        r = sb[0].pop_front();
        chk("class_a", 32'(cls_a), r.c);
        chk("dist_a", 32'(dist_a), r.d);
        chk("busy_a_after", 32'(busy_a), 0);
      end
    end
    if (rdy_b) begin
      if (sb[1].size() == 0) chk("unexpected_rdy_b", 1, 0);
      else begin
        r = sb[1].pop_front();
        chk("class_b", 32'(cls_b), r.c);
        chk("dist_b", 32'(dist_b), r.d);
        chk("busy_b_after", 32'(busy_b), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input int s);
    init_v[s] = 1'b1;
    tick();
    init_v[s] = 1'b0;
  endtask

  task automatic chunk(input int s, input int v);
    data_v[s] = 10'(v);
    rdy_v[s] = 1'b1;
    tick();
    rdy_v[s] = 1'b0;
  endtask

  // reference: plain sums per template, first strictly smallest wins
  function automatic res_t model(input int c, input int t);
    res_t r;
    int sum;
    r.c = 0;
    r.d = -1;
    for (int i = 0; i < t; i++) begin
      sum = 0;
      for (int k = 0; k < c; k++) sum += stream[i * c + k];
      if (r.d < 0 || sum < r.d) begin
        r.d = sum;
        r.c = i;
      end
    end
    return r;
  endfunction

  task automatic send(input int s, input int gap);
    int c, t;
    c = s ? 64 : 4;
    t = s ? 2 : 3;
    sb[s].push_back(model(c, t));
    pulse_init(s);
    chk("busy_start", busy_of(s), 1);
    foreach (stream[i]) begin
      repeat ($urandom_range(0, gap)) tick();
      chunk(s, stream[i]);
    end
    @(negedge clk);
    chk("rdy_early", rdy_of(s), 0);
    chk("busy_result", busy_of(s), 1);
    @(negedge clk);
    chk("rdy_latency", rdy_of(s), 1);
    for (int i = 0; i < 8 && sb[s].size() != 0; i++) @(negedge clk);
    if (sb[s].size() != 0) begin
      chk("result_timeout", 32'(sb[s].size()), 0);
      sb[s].delete();
    end
    chk("rdy_single", rdy_of(s), 0);
  endtask

  task automatic load_basic();
    stream = '{10, 20, 30, 40, 5, 5, 5, 5, 1023, 1023, 1023, 1023};
  endtask

  initial begin
    init_v = '{1'b0, 1'b0};
    rdy_v = '{1'b0, 1'b0};
    data_v = '{10'd0, 10'd0};
    repeat (3) tick();
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_rdy_a", 32'(rdy_a), 0);
    chk("rst_cls_a", 32'(cls_a), 0);
    chk("rst_dist_a", 32'(dist_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_dist_b", 32'(dist_b), 0);
    rst = 1'b1;
    tick();
    load_basic();
    send(0, 0);
    stream = '{5, 5, 5, 5, 20, 0, 0, 0, 100, 0, 0, 0};
    send(0, 0);
    stream.delete();
    repeat (64) stream.push_back(1023);
    repeat (64) stream.push_back(1022);
    send(1, 0);
    pulse_init(0);
    chunk(0, 100);
    chunk(0, 200);
    chunk(0, 300);
    chk("busy_abort", 32'(busy_a), 1);
    load_basic();
    send(0, 0);
    pulse_init(0);
    chunk(0, 7);
    chunk(0, 9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_rdy", 32'(rdy_a), 0);
    chk("midrst_cls", 32'(cls_a), 0);
    chk("midrst_dist", 32'(dist_a), 0);
    repeat (6) chunk(0, 50);
    repeat (4) tick();
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_dist", 32'(dist_a), 0);
    load_basic();
    send(0, 5);
    repeat (10) tick();
    chk("hold_cls", 32'(cls_a), 1);
    chk("hold_dist", 32'(dist_a), 20);
    for (int n = 0; n < 10; n++) begin
      stream.delete();
      repeat (12) stream.push_back($urandom_range(0, 1023));
      send(0, 3);
    end
    for (int n = 0; n < 3; n++) begin
      stream.delete();
      repeat (128) stream.push_back($urandom_range(0, 1023));
      send(1, 1);
    end
    repeat (3) tick();
    chk("sb_empty_a", 32'(sb[0].size()), 0);
    chk("sb_empty_b", 32'(sb[1].size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
